// File: rtl/beat_pkg.sv
// beat_pkg: shared definitions for the beat recorder datapath.
//   track_state_t   - per-track sequencer state encoding (IDLE, REC, PLAY)
//   NOTE_W_DEFAULT  - default number of beat pad channels per sample
//   TICK_DIV_50MHZ  - clk cycles per sample tick (1/16 s at 50 MHz)
package beat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } track_state_t;

  localparam int NOTE_W_DEFAULT = 4;
  localparam int TICK_DIV_50MHZ = 3125000;

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running sample-rate divider with synchronous clear.
// Shared by the track sequencers and other timed stages (metronome).
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   clear - restart the count at 0 on the next edge
//   tick  - one-cycle pulse while count == TICK_DIV-1
// After a clear, the first tick is seen TICK_DIV cycles later.
module sample_tick_gen #(
  parameter int TICK_DIV = 3125000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/beat_track_sequencer.sv
// beat_track_sequencer: one track of the beat recorder datapath.
// Records live pad levels into a RAM at the sample rate while record is
// high, and loops the stored take while play is high.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   record       - level; record this track (has priority over play)
//   play         - level; loop playback of this track
//   liveBeats    - live pad levels, one bit per channel
//   beatsOut     - liveBeats, ORed with the playback sample while in PLAY
//   recording    - high while in REC
//   playing      - high while in PLAY with a non-empty take
//   trackFull    - take reached DEPTH samples
//   trackLength  - number of samples in the stored take (0..DEPTH)
//   addr         - current RAM address (debug/LEDs)
// The FSM state is held in the internal signal 'state'.
module beat_track_sequencer
  import beat_pkg::*;
#(
  parameter int NOTE_W   = NOTE_W_DEFAULT,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,  // must equal 2**ADDR_W
  parameter int TICK_DIV = TICK_DIV_50MHZ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              play,
  input  logic [NOTE_W-1:0] liveBeats,
  output logic [NOTE_W-1:0] beatsOut,
  output logic              recording,
  output logic              playing,
  output logic              trackFull,
  output logic [ADDR_W:0]   trackLength,
  output logic [ADDR_W-1:0] addr
);

  localparam int LW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  track_state_t state;
  track_state_t next_state;

  logic              entry;        // state changes on the next edge
  logic              sample_tick;
  logic              mem_we;
  logic              mem_re;
  logic [NOTE_W-1:0] sticky;       // pads pressed since the last tick
  logic [NOTE_W-1:0] sample_in;
  logic [NOTE_W-1:0] playback;
  logic              has_take;

  logic [NOTE_W-1:0] mem [DEPTH];

  // Divider restarts on every state entry so the first sample lands a
  // full tick period after entering REC or PLAY.
  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (entry),
    .tick  (sample_tick)
  );

  assign has_take  = (trackLength != '0);
  assign sample_in = sticky | liveBeats;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    recording  = 1'b0;
    playing    = 1'b0;
    beatsOut   = liveBeats;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    unique case (state)
      IDLE: begin
        if (record) begin
          next_state = REC;
        end else if (play) begin
          next_state = PLAY;
        end
      end
      REC: begin
        recording = 1'b1;
        if (!record) begin
          next_state = IDLE;
        end
      end
      PLAY: begin
        playing  = has_take;
        beatsOut = liveBeats | playback;
        if (record) begin
          next_state = REC;
        end else if (!play) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    entry = (next_state != state);
    // A tick coinciding with a state change is dropped: the change wins.
    if (!reset && !entry && sample_tick) begin
      mem_we = (state == REC) && !trackFull;
      mem_re = (state == PLAY) && has_take;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= '0;
      trackLength <= '0;
      trackFull   <= 1'b0;
      sticky      <= '0;
    end else begin
      sticky <= (sample_tick || entry) ? '0 : (sticky | liveBeats);
      if (entry) begin
        addr <= '0;
        if (next_state == REC) begin
          trackLength <= '0;
          trackFull   <= 1'b0;
        end
      end else if (mem_we) begin
        trackLength <= LW'(addr) + LW'(1);
        // Last slot: addr parks at DEPTH-1 and trackFull blocks more writes.
        if (addr == LAST_ADDR) begin
          trackFull <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end else if (mem_re) begin
        addr <= (LW'(addr) == (trackLength - LW'(1))) ? '0 : addr + ADDR_W'(1);
      end
    end
  end

  // Write port and registered read in one process so this maps onto a
  // simple dual-port RAM. RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= sample_in;
    end
    if (reset || entry) begin
      playback <= '0;
    end else if (mem_re) begin
      playback <= mem[addr];
    end
  end

endmodule

// File: tb/tb_beat_track_sequencer.sv
// Bench for beat_track_sequencer with TICK_DIV=4, DEPTH=8.
// The driver pushes hand-computed expected output words into exp_q; the
// monitor pops and compares them on the falling edge.
// Observation word: {beatsOut[3:0], recording, playing, trackFull,
//                    trackLength[3:0], addr[2:0]}
module tb_beat_track_sequencer;
  import beat_pkg::*;

  localparam int W = 14;

  logic       clk = 1'b0;
  logic       reset;
  logic       record;
  logic       play;
  logic [3:0] live;
  logic [3:0] beats_out;
  logic       recording;
  logic       playing;
  logic       track_full;
  logic [3:0] track_length;
  logic [2:0] addr;
  logic [W-1:0] obs;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] exp_word;
  string        exp_name;
  logic         mismatch;
  int           checks = 0;
  int           errors = 0;

  beat_track_sequencer #(
    .NOTE_W   (4),
    .ADDR_W   (3),
    .DEPTH    (8),
    .TICK_DIV (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .record      (record),
    .play        (play),
    .liveBeats   (live),
    .beatsOut    (beats_out),
    .recording   (recording),
    .playing     (playing),
    .trackFull   (track_full),
    .trackLength (track_length),
    .addr        (addr)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  assign obs = {beats_out, recording, playing, track_full, track_length, addr};

  function automatic logic [W-1:0] mk(input logic [3:0] b, input logic r,
                                      input logic p, input logic f,
                                      input logic [3:0] l, input logic [2:0] a);
    return {b, r, p, f, l, a};
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      exp_name = name_q.pop_front();
      checks++;
      mismatch = 1'b0;
      if (beats_out !== exp_word[13:10]) begin
        mismatch = 1'b1;
        $display("FAIL %s: beatsOut got %b expected %b", exp_name, beats_out, exp_word[13:10]);
      end
      if (recording !== exp_word[9]) begin
        mismatch = 1'b1;
        $display("FAIL %s: recording got %b expected %b", exp_name, recording, exp_word[9]);
      end
      if (playing !== exp_word[8]) begin
        mismatch = 1'b1;
        $display("FAIL %s: playing got %b expected %b", exp_name, playing, exp_word[8]);
      end
      if (track_full !== exp_word[7]) begin
        mismatch = 1'b1;
        $display("FAIL %s: trackFull got %b expected %b", exp_name, track_full, exp_word[7]);
      end
      if (track_length !== exp_word[6:3]) begin
        mismatch = 1'b1;
        $display("FAIL %s: trackLength got %0d expected %0d", exp_name, track_length, exp_word[6:3]);
      end
      if (addr !== exp_word[2:0]) begin
        mismatch = 1'b1;
        $display("FAIL %s: addr got %0d expected %0d", exp_name, addr, exp_word[2:0]);
      end
      if (mismatch) begin
        errors++;
      end
    end
  end

  initial begin
    reset  = 1'b1;
    record = 1'b0;
    play   = 1'b0;
    live   = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", mk(4'b0101, 0, 0, 0, 4'd0, 3'd0));
    reset = 1'b0;
    live  = 4'b0000;

    // take 1: 0001, 0010, 0100
    record = 1'b1;
    step(1);
    live = 4'b0001;
    chk("rec_entry", mk(4'b0001, 1, 0, 0, 4'd0, 3'd0));
    step(4);
    chk("rec_s0", mk(4'b0001, 1, 0, 0, 4'd1, 3'd1));
    live = 4'b0010;
    step(4);
    chk("rec_s1", mk(4'b0010, 1, 0, 0, 4'd2, 3'd2));
    live = 4'b0100;
    step(4);
    chk("rec_s2", mk(4'b0100, 1, 0, 0, 4'd3, 3'd3));
    record = 1'b0;
    live   = 4'b0000;
    step(1);
    chk("rec_exit", mk(4'b0000, 0, 0, 0, 4'd3, 3'd0));

    // play take 1
    play = 1'b1;
    step(1);
    chk("play_entry", mk(4'b0000, 0, 1, 0, 4'd3, 3'd0));
    step(3);
    chk("play_tick_cycle", mk(4'b0000, 0, 1, 0, 4'd3, 3'd0));
    step(1);
    chk("play_s0", mk(4'b0001, 0, 1, 0, 4'd3, 3'd1));
    step(4);
    chk("play_s1", mk(4'b0010, 0, 1, 0, 4'd3, 3'd2));
    step(4);
    chk("play_s2_wrap", mk(4'b0100, 0, 1, 0, 4'd3, 3'd0));
    step(4);
    live = 4'b1000;
    chk("play_s0_again_live_or", mk(4'b1001, 0, 1, 0, 4'd3, 3'd1));
    live = 4'b0000;
    play = 1'b0;
    step(1);
    chk("play_exit", mk(4'b0000, 0, 0, 0, 4'd3, 3'd0));

    // take 2: continuous 1111 for 10 ticks, DEPTH=8
    record = 1'b1;
    live   = 4'b1111;
    step(1);
    chk("full_entry", mk(4'b1111, 1, 0, 0, 4'd0, 3'd0));
    for (int i = 0; i < 7; i++) step(4);
    chk("full_seven", mk(4'b1111, 1, 0, 0, 4'd7, 3'd7));
    step(4);
    chk("full_eight", mk(4'b1111, 1, 0, 1, 4'd8, 3'd7));
    step(8);
    chk("full_hold", mk(4'b1111, 1, 0, 1, 4'd8, 3'd7));
    record = 1'b0;
    live   = 4'b0000;
    step(1);
    chk("full_exit", mk(4'b0000, 0, 0, 1, 4'd8, 3'd0));

    // take 3: one-cycle 1000 pulse between ticks, then 0011
    record = 1'b1;
    step(1);
    chk("pulse_entry", mk(4'b0000, 1, 0, 0, 4'd0, 3'd0));
    step(1);
    live = 4'b1000;
    step(1);
    live = 4'b0000;
    step(2);
    chk("pulse_s0", mk(4'b0000, 1, 0, 0, 4'd1, 3'd1));
    live = 4'b0011;
    step(4);
    chk("pulse_s1", mk(4'b0011, 1, 0, 0, 4'd2, 3'd2));
    record = 1'b0;
    live   = 4'b0000;
    step(1);
    chk("pulse_exit", mk(4'b0000, 0, 0, 0, 4'd2, 3'd0));

    // play take 3, then reset mid-PLAY
    play = 1'b1;
    step(5);
    chk("pulse_play_s0", mk(4'b1000, 0, 1, 0, 4'd2, 3'd1));
    step(4);
    chk("pulse_play_s1_wrap", mk(4'b0011, 0, 1, 0, 4'd2, 3'd0));
    reset = 1'b1;
    step(1);
    chk("reset_mid_play", mk(4'b0000, 0, 0, 0, 4'd0, 3'd0));
    reset = 1'b0;

    // play with an empty take
    step(1);
    live = 4'b0110;
    chk("empty_play", mk(4'b0110, 0, 0, 0, 4'd0, 3'd0));
    step(5);
    chk("empty_play_after_tick", mk(4'b0110, 0, 0, 0, 4'd0, 3'd0));
    play = 1'b0;
    live = 4'b0000;
    step(1);

    // record has priority over play from IDLE
    record = 1'b1;
    play   = 1'b1;
    step(1);
    chk("priority_rec", mk(4'b0000, 1, 0, 0, 4'd0, 3'd0));
    record = 1'b0;
    play   = 1'b0;
    step(1);
    chk("priority_exit", mk(4'b0000, 0, 0, 0, 4'd0, 3'd0));

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL");
    end
    $finish;
  end

endmodule
